// File: rtl/aes_pkg.sv
// Shared constants and index helpers for the Rijndael row-shift datapath.
package aes_pkg;

    localparam int unsigned NB_MAX = 8;

    // Rijndael row offsets: the 256-bit block shifts rows 2 and 3 one column further.
    function automatic int unsigned shift_off(input int unsigned nb, input int unsigned row);
        if (nb == 8 && row >= 2) return row + 1;
        return row;
    endfunction

    function automatic int unsigned src_col(input int unsigned nb, input int unsigned col,
                                            input int unsigned row, input bit inv);
        int unsigned off;
        off = shift_off(nb, row);
        if (inv) return (col + nb - off) % nb;
        return (col + off) % nb;
    endfunction

    function automatic int unsigned byte_lsb(input int unsigned col, input int unsigned row);
        return 32 * col + 8 * row;
    endfunction

endpackage

// File: rtl/shiftrows_pipe_if.sv
// Beat-level handshake bundle between the row-shift pipe and its neighbours.
interface shiftrows_pipe_if #(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned DW = 32 * NB;

    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_data;
    logic             in_inv;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data;
    logic             out_inv;
    logic [TAG_W-1:0] out_tag;
    logic [2:0]       occupancy;
    logic             busy;

    modport master (
        output in_valid, in_data, in_inv, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_inv, out_tag, occupancy, busy
    );

    modport slave (
        input  in_valid, in_data, in_inv, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_inv, out_tag, occupancy, busy
    );

endinterface

// File: rtl/shiftrows_stage.sv
// One elastic register slice: holds a beat until downstream takes it, refills in the same cycle.
module shiftrows_stage #(
    parameter int unsigned DW    = 128,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [DW-1:0]    up_data_i,
    input  logic             up_inv_i,
    input  logic [TAG_W-1:0] up_tag_i,
    output logic             up_ready_o,
    input  logic             down_ready_i,
    output logic             valid_o,
    output logic [DW-1:0]    data_o,
    output logic             inv_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             valid_q, valid_d;
    logic [DW-1:0]    data_q, data_d;
    logic             inv_q, inv_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             adv;
    logic             load;

    assign adv        = valid_q && down_ready_i;
    assign up_ready_o = !valid_q || adv;
    assign load       = up_valid_i && up_ready_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        inv_d   = inv_q;
        tag_d   = tag_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
            inv_d   = up_inv_i;
            tag_d   = up_tag_i;
        end else if (adv) begin
            valid_d = 1'b0;
        end
        if (flush_i) valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            inv_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            inv_q   <= inv_d;
            tag_q   <= tag_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign inv_o   = inv_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/shiftrows_pipe.sv
// Rijndael ShiftRows/InvShiftRows for Nb = 4/6/8, per-beat direction, elastic pipeline with flush.
module shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB     = 4,
    parameter int unsigned STAGES = 2,
    parameter int unsigned TAG_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush_i,
    shiftrows_pipe_if.slave bus
);

    localparam int unsigned DW = 32 * NB;

    if (!(NB == 4 || NB == 6 || NB == 8) || NB > NB_MAX) begin : g_bad_nb
        $error("shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shiftrows_pipe: STAGES must be 1..4");
    end

    logic [DW-1:0] fwd_perm;
    logic [DW-1:0] inv_perm;
    logic [DW-1:0] perm;

    // Both directions are pure wiring; the per-beat direction only picks one.
    for (genvar j = 0; j < NB; j++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned DST = byte_lsb(j, r);
            localparam int unsigned SF  = byte_lsb(src_col(NB, j, r, 1'b0), r);
            localparam int unsigned SI  = byte_lsb(src_col(NB, j, r, 1'b1), r);
            assign fwd_perm[DST +: 8] = bus.in_data[SF +: 8];
            assign inv_perm[DST +: 8] = bus.in_data[SI +: 8];
        end
    end

    assign perm = bus.in_inv ? inv_perm : fwd_perm;

    logic             st_valid [STAGES];
    logic             st_ready [STAGES];
    logic [DW-1:0]    st_data  [STAGES];
    logic             st_inv   [STAGES];
    logic [TAG_W-1:0] st_tag   [STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             up_valid;
        logic [DW-1:0]    up_data;
        logic             up_inv;
        logic [TAG_W-1:0] up_tag;
        logic             down_ready;

        if (k == 0) begin : g_head
            assign up_valid = bus.in_valid && !flush_i;
            assign up_data  = perm;
            assign up_inv   = bus.in_inv;
            assign up_tag   = bus.in_tag;
        end else begin : g_body
            assign up_valid = st_valid[k-1];
            assign up_data  = st_data[k-1];
            assign up_inv   = st_inv[k-1];
            assign up_tag   = st_tag[k-1];
        end

        if (k == STAGES - 1) begin : g_tail
            assign down_ready = bus.out_ready;
        end else begin : g_mid
            assign down_ready = st_ready[k+1];
        end

        shiftrows_stage #(
            .DW    (DW),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (flush_i),
            .up_valid_i   (up_valid),
            .up_data_i    (up_data),
            .up_inv_i     (up_inv),
            .up_tag_i     (up_tag),
            .up_ready_o   (st_ready[k]),
            .down_ready_i (down_ready),
            .valid_o      (st_valid[k]),
            .data_o       (st_data[k]),
            .inv_o        (st_inv[k]),
            .tag_o        (st_tag[k])
        );
    end

    logic       accept;
    logic       deliver;
    logic [2:0] occ_q, occ_d;

    assign bus.in_ready  = !flush_i && st_ready[0];
    assign bus.out_valid = st_valid[STAGES-1];
    assign bus.out_data  = st_data[STAGES-1];
    assign bus.out_inv   = st_inv[STAGES-1];
    assign bus.out_tag   = st_tag[STAGES-1];

    assign accept  = bus.in_valid && bus.in_ready;
    assign deliver = bus.out_valid && bus.out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush_i) begin
            occ_d = 3'd0;
        end else if (accept && !deliver) begin
            occ_d = occ_q + 3'd1;
        end else if (deliver && !accept) begin
            occ_d = occ_q - 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) occ_q <= 3'd0;
        else     occ_q <= occ_d;
    end

    assign bus.occupancy = occ_q;
    assign bus.busy      = (occ_q != 3'd0);

endmodule

// File: tb/tb_shiftrows_pipe.sv
// Self-checking bench for shiftrows_pipe: vector table, corner sequences, random scoreboard.
module tb_shiftrows_pipe;

    logic clk = 1'b0;
    logic rst;
    logic flush4;
    logic flush8;

    always #5 clk = ~clk;

    shiftrows_pipe_if #(.NB(4), .TAG_W(4)) b4 ();
    shiftrows_pipe_if #(.NB(8), .TAG_W(4)) b8 ();

    shiftrows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush4),
        .bus     (b4.slave)
    );

    shiftrows_pipe #(.NB(8), .STAGES(3), .TAG_W(4)) dut8 (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush8),
        .bus     (b8.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: state as a 4 x nb byte grid, rows rotated by their Rijndael offset.
    function automatic logic [255:0] sr_model(input int nb, input logic [255:0] d, input logic inv);
        logic [7:0]   grid [4][8];
        logic [255:0] o;
        int           off;
        int           src;
        o = '0;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) grid[r][c] = d[32*c+8*r +: 8];
        for (int c = 0; c < nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                off = (nb == 8 && r >= 2) ? r + 1 : r;
                src = inv ? (c - off + nb) % nb : (c + off) % nb;
                o[32*c+8*r +: 8] = grid[r][src];
            end
        end
        return o;
    endfunction

    typedef struct {
        logic [127:0] d;
        logic         inv;
        logic [127:0] exp;
    } vec_t;

    typedef struct {
        logic [127:0] d;
        logic         inv;
        logic [3:0]   tag;
    } beat_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs [4];
        logic [127:0] beats [16];
        logic [255:0] data8;
        logic [255:0] res8;
        beat_t        q [$];
        beat_t        b;
        int           accepted;
        int           got_n;
        int           tag;
        int           lat;
        logic         seen;
        logic         prev_stall;
        logic [127:0] prev_data;

        vecs[0] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b0,
                    128'h0b06010c07020d08030e09040f0a0500};
        vecs[1] = '{128'h0b06010c07020d08030e09040f0a0500, 1'b1,
                    128'h0f0e0d0c0b0a09080706050403020100};
        vecs[2] = '{128'h0f0e0d0c0b0a09080706050403020100, 1'b1,
                    128'h0306090c0f0205080b0e0104070a0d00};
        vecs[3] = '{128'h0, 1'b1, 128'h0};

        rst = 1'b1;
        flush4 = 1'b0;
        flush8 = 1'b0;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_inv = 1'b0; b4.in_tag = '0;
        b4.out_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.in_inv = 1'b0; b8.in_tag = '0;
        b8.out_ready = 1'b1;

        #2;
        chk("rst_out_valid", b4.out_valid, 0);
        chk("rst_out_data", b4.out_data, 0);
        chk("rst_out_inv", b4.out_inv, 0);
        chk("rst_out_tag", b4.out_tag, 0);
        chk("rst_occupancy", b4.occupancy, 0);
        chk("rst_busy", b4.busy, 0);
        chk("rst8_out_valid", b8.out_valid, 0);
        step();
        step();
        #3 rst = 1'b0;
        step();

        // Vector table: exact two-cycle latency and expected permutation.
        for (int i = 0; i < 4; i++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = vecs[i].d;
            b4.in_inv   = vecs[i].inv;
            b4.in_tag   = 4'(i);
            #1;
            chk("vec_in_ready", b4.in_ready, 1);
            step();
            b4.in_valid = 1'b0;
            chk("vec_lat1_valid", b4.out_valid, 0);
            chk("vec_lat1_occ", b4.occupancy, 1);
            step();
            chk("vec_out_valid", b4.out_valid, 1);
            chk("vec_out_data", b4.out_data, vecs[i].exp);
            chk("vec_out_inv", b4.out_inv, vecs[i].inv);
            chk("vec_out_tag", b4.out_tag, i);
            step();
        end

        // 16 back-to-back beats, alternating direction, one result per cycle.
        for (int t = 0; t < 20; t++) begin
            if (t < 16) begin
                beats[t]    = {$urandom, $urandom, $urandom, $urandom};
                b4.in_valid = 1'b1;
                b4.in_data  = beats[t];
                b4.in_inv   = t[0];
                b4.in_tag   = 4'(t);
            end else begin
                b4.in_valid = 1'b0;
            end
            #1;
            if (t < 16) chk("alt_in_ready", b4.in_ready, 1);
            chk("alt_out_valid", b4.out_valid, (t >= 2 && t < 18));
            if (t >= 2 && t < 18) begin
                chk("alt_out_data", b4.out_data, sr_model(4, beats[t-2], (t - 2) % 2 == 1));
                chk("alt_out_inv", b4.out_inv, (t - 2) % 2);
                chk("alt_out_tag", b4.out_tag, t - 2);
            end
            step();
        end

        // NB=8: forward then inverse round trip.
        for (int i = 0; i < 32; i++) data8[8*i +: 8] = 8'(i);
        b8.in_valid = 1'b1;
        b8.in_data  = data8;
        b8.in_inv   = 1'b0;
        step();
        b8.in_valid = 1'b0;
        lat = 1;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (b8.out_valid) seen = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        chk("nb8_fwd_seen", seen, 1);
        chk("nb8_latency", lat, 3);
        chk("nb8_c0_row2", b8.out_data[23:16], 8'h0e);
        chk("nb8_c0_row3", b8.out_data[31:24], 8'h13);
        chk("nb8_fwd_data", b8.out_data, sr_model(8, data8, 1'b0));
        res8 = b8.out_data;
        step();
        b8.in_valid = 1'b1;
        b8.in_data  = res8;
        b8.in_inv   = 1'b1;
        step();
        b8.in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (b8.out_valid) seen = 1'b1;
            else step();
        end
        chk("nb8_inv_seen", seen, 1);
        chk("nb8_inv_restore", b8.out_data, data8);
        chk("nb8_inv_flag", b8.out_inv, 1);
        step();

        // Backpressure: only STAGES beats fit while the output is stalled.
        b4.out_ready = 1'b0;
        accepted = 0;
        tag = 1;
        for (int c = 0; c < 5; c++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = {$urandom, $urandom, $urandom, $urandom};
            b4.in_inv   = 1'b0;
            b4.in_tag   = 4'(tag);
            #1;
            chk("bp_in_ready", b4.in_ready, accepted < 2);
            if (b4.in_ready) begin
                accepted++;
                tag++;
            end
            step();
        end
        chk("bp_occupancy", b4.occupancy, 2);
        chk("bp_busy", b4.busy, 1);
        b4.out_ready = 1'b1;
        got_n = 0;
        for (int c = 0; c < 30 && got_n < 5; c++) begin
            b4.in_valid = (tag <= 5);
            b4.in_tag   = 4'(tag);
            b4.in_data  = {$urandom, $urandom, $urandom, $urandom};
            #1;
            if (b4.out_valid && b4.out_ready) begin
                chk("bp_tag_order", b4.out_tag, got_n + 1);
                got_n++;
            end
            if (b4.in_valid && b4.in_ready) tag++;
            step();
        end
        chk("bp_all_tags", got_n, 5);
        b4.in_valid = 1'b0;
        #1;
        chk("bp_no_dup", b4.out_valid, 0);
        step();

        // Flush with two beats in flight and an input beat offered.
        b4.out_ready = 1'b0;
        b4.in_valid  = 1'b1;
        b4.in_tag    = 4'd7;
        step();
        b4.in_tag = 4'd8;
        step();
        chk("fl_pre_occ", b4.occupancy, 2);
        b4.in_tag = 4'd9;
        flush4 = 1'b1;
        #1;
        chk("fl_in_ready", b4.in_ready, 0);
        chk("fl_out_valid_hold", b4.out_valid, 1);
        step();
        flush4 = 1'b0;
        b4.in_valid = 1'b0;
        chk("fl_out_valid", b4.out_valid, 0);
        chk("fl_occupancy", b4.occupancy, 0);
        chk("fl_busy", b4.busy, 0);
        b4.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("fl_no_ghost", b4.out_valid, 0);
            step();
        end

        // Asynchronous reset between edges while streaming.
        for (int c = 0; c < 3; c++) begin
            b4.in_valid = 1'b1;
            b4.in_data  = {$urandom, $urandom, $urandom, $urandom} | 128'h1;
            b4.in_inv   = 1'b0;
            b4.in_tag   = 4'(c + 1);
            step();
        end
        chk("ar_pre_valid", b4.out_valid, 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_out_valid", b4.out_valid, 0);
        chk("ar_out_data", b4.out_data, 0);
        chk("ar_occupancy", b4.occupancy, 0);
        #2 rst = 1'b0;
        b4.in_valid = 1'b0;
        step();
        chk("ar_post_valid", b4.out_valid, 0);

        // Random streaming against the scoreboard.
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 500; c++) begin
            b4.in_valid  = ($urandom_range(0, 9) < 7);
            b4.in_data   = {$urandom, $urandom, $urandom, $urandom};
            b4.in_inv    = 1'($urandom_range(0, 1));
            b4.in_tag    = 4'($urandom_range(0, 15));
            b4.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            chk("rnd_occupancy", b4.occupancy, q.size());
            chk("rnd_in_ready", b4.in_ready, (q.size() < 2) || b4.out_ready);
            if (prev_stall) begin
                chk("rnd_stall_valid", b4.out_valid, 1);
                chk("rnd_stall_data", b4.out_data, prev_data);
            end
            if (b4.out_valid && b4.out_ready) begin
                if (q.size() == 0) begin
                    chk("rnd_spurious_out", 1, 0);
                end else begin
                    b = q.pop_front();
                    chk("rnd_out_data", b4.out_data, b.d);
                    chk("rnd_out_inv", b4.out_inv, b.inv);
                    chk("rnd_out_tag", b4.out_tag, b.tag);
                end
            end
            if (b4.in_valid && b4.in_ready)
                q.push_back('{sr_model(4, b4.in_data, b4.in_inv), b4.in_inv, b4.in_tag});
            prev_stall = b4.out_valid && !b4.out_ready;
            prev_data  = b4.out_data;
            step();
        end
        b4.in_valid  = 1'b0;
        b4.out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) begin
            #1;
            if (b4.out_valid) begin
                b = q.pop_front();
                chk("drain_out_data", b4.out_data, b.d);
                chk("drain_out_tag", b4.out_tag, b.tag);
            end
            step();
        end
        chk("drain_empty", q.size(), 0);
        chk("drain_occupancy", b4.occupancy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
